bcd_seq_converter: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter with per-digit 7-segment drive.
//  - Uses shift-add-3 (double dabble), one bit per clock.
//  - Uses a valid/ready handshake on both the input and the output side.
//  - Sits between datapath results (counters, ALU outputs) and the board HEX displays.
//  - Replaces the combinational divide/modulo conversion, which was fixed at 4 bits and 2 digits.

---
 rtl/bcd_seq_converter_pkg.sv | 22 ++
 rtl/bcd_seq_converter_if.sv | 14 +
 rtl/bcd_seq_converter_seg_decoder.sv | 13 +
 rtl/bcd_seq_converter.sv | 79 +++++++
 tb/tb_bcd_seq_converter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seq_converter_pkg.sv
// bcd_pkg: shared FSM state type, 7-segment constants and the digit-to-segment lookup.
//   Segment encoding is active-low {g,f,e,d,c,b,a}; codes 10..15 decode to blank.
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      case (d)
         4'd0: seg_lut = SEG_ZERO;
         4'd1: seg_lut = 7'b1111001;
         4'd2: seg_lut = 7'b0100100;
         4'd3: seg_lut = 7'b0110000;
         4'd4: seg_lut = 7'b0011001;
         4'd5: seg_lut = 7'b0010010;
         4'd6: seg_lut = 7'b0000010;
         4'd7: seg_lut = 7'b1111000;
         4'd8: seg_lut = 7'b0000000;
         4'd9: seg_lut = 7'b0010000;
         default: seg_lut = SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/bcd_seq_converter_if.sv
// bcd_seq_converter_if: input and output valid/ready channels of the converter.
//   master: drives in_valid, bin_in, out_ready (producer/consumer side)
//   slave : drives in_ready, out_valid, bcd_out, seg_out (converter side)
interface bcd_seq_converter_if #(parameter int WIDTH = 8, parameter int NUM_DIGITS = 3);
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        bin_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [7*NUM_DIGITS-1:0] seg_out;
   modport master (output in_valid, bin_in, out_ready, input in_ready, out_valid, bcd_out, seg_out);
   modport slave (input in_valid, bin_in, out_ready, output in_ready, out_valid, bcd_out, seg_out);
endinterface

// File: rtl/bcd_seq_converter_seg_decoder.sv
// bcd_seg_decoder: combinational BCD digit to active-low 7-segment pattern.
//   digit in 4  BCD code
//   blank in 1  force all segments off
//   seg   out 7 active-low {g..a}
module bcd_seg_decoder
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);
   assign seg = blank ? SEG_BLANK : seg_lut(digit);
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble binary-to-BCD converter with 7-segment drive.
//   clk, rst_n (async active-low), bus (slave modport: in/out valid-ready, bcd_out, seg_out),
//   busy (conversion in progress). Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_seq_converter_if.slave  bus,
   output logic                busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * NUM_DIGITS;
   if (longint'(10) ** NUM_DIGITS < (longint'(1) << WIDTH)) begin : g_range_chk
      $error("bcd_seq_converter: NUM_DIGITS too small for WIDTH");
   end
   bcd_state_t          state;
   logic [BW-1:0]       scratch, adj, bcd_q;
   logic [WIDTH-1:0]    bin;
   logic [CW-1:0]       cnt;
   logic                ov;
   logic [BW+WIDTH-1:0] shifted;
   logic [7*NUM_DIGITS-1:0] seg;
   logic                accept;
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
      assign adj[4*d+:4] = scratch[4*d+:4] >= 4'd5 ? scratch[4*d+:4] + 4'd3 : scratch[4*d+:4];
   end
   assign shifted      = {adj, bin} << 1;
   assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.out_valid = ov;
   assign bus.bcd_out  = bcd_q;
   assign bus.seg_out  = seg;
   assign busy         = state == SHIFT;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ov      <= 1'b0;
         scratch <= '0;
         bin     <= '0;
         cnt     <= '0;
         bcd_q   <= '0;
      end else if (accept) begin
         bin     <= bus.bin_in;
         scratch <= '0;
         cnt     <= CW'(WIDTH);
         ov      <= 1'b0;
         state   <= SHIFT;
      end else if (state == SHIFT) begin
         {scratch, bin} <= shifted;
         cnt            <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            bcd_q <= shifted[BW+WIDTH-1:WIDTH];
            ov    <= 1'b1;
            state <= DONE;
         end
      end else if (state == DONE && bus.out_ready) begin
         ov    <= 1'b0;
         state <= IDLE;
      end
   end
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic blank;
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 0) begin : g_lsd
         assign blank = 1'b0;
      end else begin : g_msd
         // blank when this digit and every digit above it are zero
         assign blank = bcd_q[BW-1:4*i] == '0;
      end
`else
      assign blank = 1'b0;
`endif
      bcd_seg_decoder u_dec (.digit(bcd_q[4*i+:4]), .blank(blank), .seg(seg[7*i+:7]));
   end
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed and random checks of three converter configurations against a decimal model.
module tb_bcd_seq_converter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bin = '0;
   logic [2:0]  iv = '0;
   logic        oro = 1'b0;
   logic        busy8, busy4, busy16;
   int          errors = 0;
   int          checks = 0;
   int          wid[3] = '{8, 4, 16};
   int          ndg[3] = '{3, 2, 5};
   logic [6:0]  seg_tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clk = ~clk;

   bcd_seq_converter_if #(.WIDTH(8),  .NUM_DIGITS(3)) i8 ();
   bcd_seq_converter_if #(.WIDTH(4),  .NUM_DIGITS(2)) i4 ();
   bcd_seq_converter_if #(.WIDTH(16), .NUM_DIGITS(5)) i16 ();
   assign i8.in_valid   = iv[0];
   assign i4.in_valid   = iv[1];
   assign i16.in_valid  = iv[2];
   assign i8.bin_in     = bin[7:0];
   assign i4.bin_in     = bin[3:0];
   assign i16.bin_in    = bin;
   assign i8.out_ready  = oro;
   assign i4.out_ready  = oro;
   assign i16.out_ready = oro;

   bcd_seq_converter #(.WIDTH(8),  .NUM_DIGITS(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave),  .busy(busy8));
   bcd_seq_converter #(.WIDTH(4),  .NUM_DIGITS(2)) dut4  (.clk(clk), .rst_n(rst_n), .bus(i4.slave),  .busy(busy4));
   bcd_seq_converter #(.WIDTH(16), .NUM_DIGITS(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave), .busy(busy16));

   function automatic logic rdy(int s);
      return s == 0 ? i8.in_ready : s == 1 ? i4.in_ready : i16.in_ready;
   endfunction
   function automatic logic ovld(int s);
      return s == 0 ? i8.out_valid : s == 1 ? i4.out_valid : i16.out_valid;
   endfunction
   function automatic logic [19:0] bcd_o(int s);
      return s == 0 ? 20'(i8.bcd_out) : s == 1 ? 20'(i4.bcd_out) : i16.bcd_out;
   endfunction
   function automatic logic [34:0] seg_o(int s);
      return s == 0 ? 35'(i8.seg_out) : s == 1 ? 35'(i4.seg_out) : i16.seg_out;
   endfunction

   function automatic logic [19:0] ref_bcd(int v, int nd);
      logic [19:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i+:4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [34:0] ref_seg(int v, int nd);
      logic [34:0] r = '0;
      int x = v;
      int dig[5];
      int msd = 0;
      for (int i = 0; i < nd; i++) begin
         dig[i] = x % 10;
         x = x / 10;
         if (dig[i] != 0) msd = i;
      end
      for (int i = 0; i < nd; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
         r[7*i+:7] = i > msd ? 7'h7F : seg_tbl[dig[i]];
`else
         r[7*i+:7] = seg_tbl[dig[i]];
`endif
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic conv(input int s, input int v, input bit consume);
      int n = 0;
      while (!rdy(s) && n < 60) begin tick(); n++; end
      chk("in_ready_before_accept", 64'(rdy(s)), 64'd1);
      bin = 16'(v);
      iv[s] = 1'b1;
      tick();
      iv = '0;
      n = 0;
      while (!ovld(s) && n < 60) begin tick(); n++; end
      chk($sformatf("latency w%0d v%0d", wid[s], v), 64'(n), 64'(wid[s]));
      chk($sformatf("bcd w%0d v%0d", wid[s], v), 64'(bcd_o(s)), 64'(ref_bcd(v, ndg[s])));
      chk($sformatf("seg w%0d v%0d", wid[s], v), 64'(seg_o(s)), 64'(ref_seg(v, ndg[s])));
      if (consume) begin
         oro = 1'b1;
         tick();
         oro = 1'b0;
         chk("consumed_out_valid", 64'(ovld(s)), 64'd0);
         chk("bcd_hold_after_handshake", 64'(bcd_o(s)), 64'(ref_bcd(v, ndg[s])));
      end
   endtask

   initial begin
      int n;
      int seen;
      // reset state
      repeat (3) tick();
      chk("rst_in_ready", 64'(i8.in_ready), 64'd1);
      chk("rst_out_valid", 64'(i8.out_valid), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_bcd", 64'(i8.bcd_out), 64'd0);
      chk("rst_seg", 64'(i8.seg_out), 64'(ref_seg(0, 3)));
      rst_n = 1'b1;
      tick();
      // max value and zero
      conv(0, 255, 1);
      chk("bcd_255_literal", 64'(i8.bcd_out), 64'h255);
      conv(0, 0, 1);
      chk("bcd_0_literal", 64'(i8.bcd_out), 64'h000);
      // back-to-back 99 then 100
      oro = 1'b1;
      bin = 16'd99;
      iv[0] = 1'b1;
      tick();
      bin = 16'd100;
      n = 0;
      while (!i8.out_valid && n < 60) begin tick(); n++; end
      chk("b2b_latency_first", 64'(n), 64'd8);
      chk("b2b_bcd_first", 64'(i8.bcd_out), 64'h099);
      chk("b2b_in_ready_done", 64'(i8.in_ready), 64'd1);
      tick();
      iv = '0;
      chk("b2b_busy_second", 64'(busy8), 64'd1);
      chk("b2b_out_valid_dropped", 64'(i8.out_valid), 64'd0);
      n = 1;
      while (!i8.out_valid && n < 60) begin tick(); n++; end
      chk("b2b_spacing", 64'(n), 64'd9);
      chk("b2b_bcd_second", 64'(i8.bcd_out), 64'h100);
      tick();
      oro = 1'b0;
      chk("b2b_consumed", 64'(i8.out_valid), 64'd0);
      // backpressure on result 42
      conv(0, 42, 0);
      bin = 16'd7;
      iv[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_out_valid", 64'(i8.out_valid), 64'd1);
         chk("bp_bcd", 64'(i8.bcd_out), 64'h042);
         chk("bp_in_ready", 64'(i8.in_ready), 64'd0);
      end
      iv = '0;
      oro = 1'b1;
      tick();
      oro = 1'b0;
      tick();
      chk("bp_no_accept_busy", 64'(busy8), 64'd0);
      chk("bp_idle_ready", 64'(i8.in_ready), 64'd1);
      chk("bp_bcd_kept", 64'(i8.bcd_out), 64'h042);
      // async reset mid-conversion
      bin = 16'd200;
      iv[0] = 1'b1;
      tick();
      iv = '0;
      repeat (3) tick();
      chk("mid_busy_before_reset", 64'(busy8), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(i8.in_ready), 64'd1);
      chk("mid_rst_out_valid", 64'(i8.out_valid), 64'd0);
      chk("mid_rst_bcd", 64'(i8.bcd_out), 64'd0);
      chk("mid_rst_busy", 64'(busy8), 64'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i8.out_valid || busy8) seen++;
      end
      chk("mid_rst_no_stale", 64'(seen), 64'd0);
      // random values on the 8-bit converter
      for (int i = 0; i < 20; i++) conv(0, int'($urandom_range(0, 255)), 1);
      // 4-bit sweep
      for (int v = 0; v < 16; v++) conv(1, v, 1);
      chk("w4_15_literal", 64'(i4.bcd_out), 64'h15);
      // 16-bit corners and random
      conv(2, 0, 1);
      conv(2, 9999, 1);
      conv(2, 65535, 1);
      chk("w16_max_literal", 64'(i16.bcd_out), 64'h65535);
      for (int i = 0; i < 5; i++) conv(2, int'($urandom_range(0, 65535)), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
